// File: rtl/tlb_walk_arbiter.sv
// Arbitrates the I-TLB and D-TLB miss paths onto the single MMU page-walk port.
// One walk in flight, round-robin on ties, stuck-walk watchdog and per-side grant counters.
module tlb_walk_arbiter #(
  parameter int unsigned VPN_BITS       = 64,
  parameter int unsigned EXTENDED_PPN   = 52,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32,
  parameter type         tlb_perm_bits  = logic [7:0]
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_valid,
  input  logic [VPN_BITS-1:0]     i_req_addr,
  output logic                    i_resp_valid,
  input  logic                    d_req_valid,
  input  logic [VPN_BITS-1:0]     d_req_addr,
  output logic                    d_resp_valid,
  output logic [EXTENDED_PPN-1:0] resp_addr,
  output tlb_perm_bits            resp_perm,
  output logic                    mmu_req_valid,
  output logic [VPN_BITS-1:0]     mmu_req_addr,
  input  logic                    mmu_resp_valid,
  input  logic [EXTENDED_PPN-1:0] mmu_resp_addr,
  input  tlb_perm_bits            mmu_resp_perm,
  output logic                    timeout_err,
  output logic [CNT_W-1:0]        i_grant_cnt,
  output logic [CNT_W-1:0]        d_grant_cnt
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_GAP = 2'd2} state_e;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  side_e                   last_grant_q, last_grant_d;
  side_e                   grant_q, grant_d;
  logic                    mmu_req_valid_q, mmu_req_valid_d;
  logic [VPN_BITS-1:0]     mmu_req_addr_q, mmu_req_addr_d;
  logic                    i_resp_valid_q, i_resp_valid_d;
  logic                    d_resp_valid_q, d_resp_valid_d;
  logic [EXTENDED_PPN-1:0] resp_addr_q, resp_addr_d;
  tlb_perm_bits            resp_perm_q, resp_perm_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [31:0]             wdog_q, wdog_d;
  logic [CNT_W-1:0]        i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]        d_cnt_q, d_cnt_d;

  // Next-state and next-output computation for the IDLE/WAIT/GAP walk sequencer.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_d         = grant_q;
    mmu_req_valid_d = mmu_req_valid_q;
    mmu_req_addr_d  = mmu_req_addr_q;
    i_resp_valid_d  = 1'b0;
    d_resp_valid_d  = 1'b0;
    resp_addr_d     = resp_addr_q;
    resp_perm_d     = resp_perm_q;
    timeout_err_d   = timeout_err_q;
    wdog_d          = wdog_q;
    i_cnt_d         = i_cnt_q;
    d_cnt_d         = d_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid || d_req_valid) begin
          // On a tie the side that did not win last time gets the port.
          if (i_req_valid && (!d_req_valid || (last_grant_q == SIDE_D))) begin
            grant_d        = SIDE_I;
            mmu_req_addr_d = i_req_addr;
          end else begin
            grant_d        = SIDE_D;
            mmu_req_addr_d = d_req_addr;
          end
          mmu_req_valid_d = 1'b1;
          wdog_d          = 32'd0;
          state_d         = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mmu_resp_valid) begin
          resp_addr_d     = mmu_resp_addr;
          resp_perm_d     = mmu_resp_perm;
          mmu_req_valid_d = 1'b0;
          last_grant_d    = grant_q;
          wdog_d          = 32'd0;
          state_d         = ST_GAP;
          if (grant_q == SIDE_I) begin
            i_resp_valid_d = 1'b1;
            i_cnt_d        = i_cnt_q + CNT_W'(1'b1);
          end else begin
            d_resp_valid_d = 1'b1;
            d_cnt_d        = d_cnt_q + CNT_W'(1'b1);
          end
        end else begin
          wdog_d = wdog_q + 32'd1;
          // The walk is kept alive after the watchdog fires; only the flag is raised.
          if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
            timeout_err_d = 1'b1;
          end else begin
            timeout_err_d = timeout_err_q;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any walk in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= SIDE_D;
      grant_q         <= SIDE_I;
      mmu_req_valid_q <= 1'b0;
      mmu_req_addr_q  <= '0;
      i_resp_valid_q  <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      resp_addr_q     <= '0;
      resp_perm_q     <= '0;
      timeout_err_q   <= 1'b0;
      wdog_q          <= 32'd0;
      i_cnt_q         <= '0;
      d_cnt_q         <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_q         <= grant_d;
      mmu_req_valid_q <= mmu_req_valid_d;
      mmu_req_addr_q  <= mmu_req_addr_d;
      i_resp_valid_q  <= i_resp_valid_d;
      d_resp_valid_q  <= d_resp_valid_d;
      resp_addr_q     <= resp_addr_d;
      resp_perm_q     <= resp_perm_d;
      timeout_err_q   <= timeout_err_d;
      wdog_q          <= wdog_d;
      i_cnt_q         <= i_cnt_d;
      d_cnt_q         <= d_cnt_d;
    end
  end

  assign mmu_req_valid = mmu_req_valid_q;
  assign mmu_req_addr  = mmu_req_addr_q;
  assign i_resp_valid  = i_resp_valid_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign resp_addr     = resp_addr_q;
  assign resp_perm     = resp_perm_q;
  assign timeout_err   = timeout_err_q;
  assign i_grant_cnt   = i_cnt_q;
  assign d_grant_cnt   = d_cnt_q;

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Directed bench for tlb_walk_arbiter: arbitration order, address latching,
// watchdog, spurious responses and reset during a walk.
module tb_tlb_walk_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req_valid;
  logic [63:0] i_req_addr;
  logic        i_resp_valid;
  logic        d_req_valid;
  logic [63:0] d_req_addr;
  logic        d_resp_valid;
  logic [51:0] resp_addr;
  logic [7:0]  resp_perm;
  logic        mmu_req_valid;
  logic [63:0] mmu_req_addr;
  logic        mmu_resp_valid;
  logic [51:0] mmu_resp_addr;
  logic [7:0]  mmu_resp_perm;
  logic        timeout_err;
  logic [31:0] i_grant_cnt;
  logic [31:0] d_grant_cnt;

  int passed = 0;
  int total  = 0;

  tlb_walk_arbiter #(
    .VPN_BITS(64), .EXTENDED_PPN(52), .TIMEOUT_CYCLES(8), .CNT_W(32),
    .tlb_perm_bits(logic [7:0])
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_resp_valid(i_resp_valid),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_resp_valid(d_resp_valid),
    .resp_addr(resp_addr), .resp_perm(resp_perm),
    .mmu_req_valid(mmu_req_valid), .mmu_req_addr(mmu_req_addr),
    .mmu_resp_valid(mmu_resp_valid), .mmu_resp_addr(mmu_resp_addr),
    .mmu_resp_perm(mmu_resp_perm),
    .timeout_err(timeout_err), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester must be held by the caller; state must be IDLE on entry.
  task automatic do_walk(input logic exp_i, input logic [63:0] exp_addr,
                         input logic [51:0] ppn, input logic [7:0] perm, input int lat);
    step();
    chk("walk_mmu_req_valid", {63'd0, mmu_req_valid}, 64'd1);
    chk("walk_mmu_req_addr", mmu_req_addr, exp_addr);
    repeat (lat - 1) step();
    chk("walk_held_valid", {63'd0, mmu_req_valid}, 64'd1);
    mmu_resp_valid = 1'b1;
    mmu_resp_addr  = ppn;
    mmu_resp_perm  = perm;
    step();
    mmu_resp_valid = 1'b0;
    chk("walk_i_resp", {63'd0, i_resp_valid}, {63'd0, exp_i});
    chk("walk_d_resp", {63'd0, d_resp_valid}, {63'd0, ~exp_i});
    chk("walk_resp_addr", {12'd0, resp_addr}, {12'd0, ppn});
    chk("walk_resp_perm", {56'd0, resp_perm}, {56'd0, perm});
    chk("walk_mmu_drop", {63'd0, mmu_req_valid}, 64'd0);
    step();
    chk("walk_pulse_end", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk("walk_resp_hold", {12'd0, resp_addr}, {12'd0, ppn});
    if (exp_i) i_req_valid = 1'b0;
    else       d_req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_req_addr = 64'd0; d_req_addr = 64'd0;
    mmu_resp_valid = 1'b0; mmu_resp_addr = 52'd0; mmu_resp_perm = 8'd0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    chk("rst_mmu_req_valid", {63'd0, mmu_req_valid}, 64'd0);
    chk("rst_resp_valids", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk("rst_resp_addr", {12'd0, resp_addr}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
    chk("rst_counts", {i_grant_cnt, d_grant_cnt}, 64'd0);

    // Single I request
    i_req_valid = 1'b1; i_req_addr = 64'h1234;
    do_walk(1'b1, 64'h1234, 52'hABCDE, 8'h0F, 3);
    chk("single_i_cnt", {32'd0, i_grant_cnt}, 64'd1);
    chk("single_d_cnt", {32'd0, d_grant_cnt}, 64'd0);
    step();
    chk("single_idle", {63'd0, mmu_req_valid}, 64'd0);

    // Simultaneous I/D from reset: order I, D, I, D
    reset = 1'b1; step(); reset = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 64'h1000;
    d_req_valid = 1'b1; d_req_addr = 64'h2000;
    do_walk(1'b1, 64'h1000, 52'h11111, 8'h01, 2);
    do_walk(1'b0, 64'h2000, 52'h22222, 8'h02, 1);
    i_req_valid = 1'b1; i_req_addr = 64'h1100;
    d_req_valid = 1'b1; d_req_addr = 64'h2200;
    do_walk(1'b1, 64'h1100, 52'h33333, 8'h03, 2);
    do_walk(1'b0, 64'h2200, 52'h44444, 8'h04, 4);
    chk("rr_i_cnt", {32'd0, i_grant_cnt}, 64'd2);
    chk("rr_d_cnt", {32'd0, d_grant_cnt}, 64'd2);

    // D held; I arrives and changes address during WAIT
    d_req_valid = 1'b1; d_req_addr = 64'h5555;
    step();
    chk("latch_grant_addr", mmu_req_addr, 64'h5555);
    i_req_valid = 1'b1; i_req_addr = 64'hAAAA;
    step();
    chk("latch_hold1", mmu_req_addr, 64'h5555);
    i_req_addr = 64'hBBBB; d_req_addr = 64'hCCCC;
    step();
    chk("latch_hold2", mmu_req_addr, 64'h5555);
    mmu_resp_valid = 1'b1; mmu_resp_addr = 52'h66666; mmu_resp_perm = 8'h06;
    step();
    mmu_resp_valid = 1'b0;
    chk("latch_d_resp", {63'd0, d_resp_valid}, 64'd1);
    chk("latch_i_resp", {63'd0, i_resp_valid}, 64'd0);
    step();
    d_req_valid = 1'b0;
    // I waited during the D walk and is granted right after GAP
    do_walk(1'b1, 64'hBBBB, 52'h77777, 8'h07, 1);
    chk("b2b_counts", {i_grant_cnt, d_grant_cnt}, {32'd3, 32'd3});

    // Watchdog: TIMEOUT_CYCLES = 8, MMU silent for 20 cycles
    i_req_valid = 1'b1; i_req_addr = 64'h7777;
    step();
    chk("wd_grant", {63'd0, mmu_req_valid}, 64'd1);
    repeat (7) step();
    chk("wd_not_yet", {63'd0, timeout_err}, 64'd0);
    step();
    chk("wd_fired", {63'd0, timeout_err}, 64'd1);
    repeat (11) step();
    chk("wd_sticky", {63'd0, timeout_err}, 64'd1);
    chk("wd_req_kept", {63'd0, mmu_req_valid}, 64'd1);
    chk("wd_addr_kept", mmu_req_addr, 64'h7777);
    mmu_resp_valid = 1'b1; mmu_resp_addr = 52'h88888; mmu_resp_perm = 8'h08;
    step();
    mmu_resp_valid = 1'b0;
    chk("wd_i_resp", {63'd0, i_resp_valid}, 64'd1);
    chk("wd_d_resp", {63'd0, d_resp_valid}, 64'd0);
    chk("wd_i_cnt", {32'd0, i_grant_cnt}, 64'd4);
    step();
    i_req_valid = 1'b0;
    chk("wd_sticky_after", {63'd0, timeout_err}, 64'd1);

    // Spurious MMU response while IDLE
    mmu_resp_valid = 1'b1; mmu_resp_addr = 52'hFFFFF; mmu_resp_perm = 8'hAA;
    step();
    mmu_resp_valid = 1'b0;
    chk("spur_resp_valids", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk("spur_resp_addr", {12'd0, resp_addr}, 64'h88888);
    chk("spur_resp_perm", {56'd0, resp_perm}, 64'h08);
    chk("spur_counts", {i_grant_cnt, d_grant_cnt}, {32'd4, 32'd3});
    step();
    chk("spur_no_req", {63'd0, mmu_req_valid}, 64'd0);

    // Reset in the middle of a walk, then a late response
    d_req_valid = 1'b1; d_req_addr = 64'h9999;
    step();
    step();
    chk("midrst_in_wait", {63'd0, mmu_req_valid}, 64'd1);
    reset = 1'b1; d_req_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("midrst_req", {63'd0, mmu_req_valid}, 64'd0);
    chk("midrst_req_addr", mmu_req_addr, 64'd0);
    chk("midrst_resp", {12'd0, resp_addr}, 64'd0);
    chk("midrst_flags", {54'd0, resp_perm, timeout_err, i_resp_valid}, 64'd0);
    chk("midrst_counts", {i_grant_cnt, d_grant_cnt}, 64'd0);
    mmu_resp_valid = 1'b1; mmu_resp_addr = 52'h12345; mmu_resp_perm = 8'h55;
    step();
    mmu_resp_valid = 1'b0;
    chk("late_resp_valids", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    chk("late_resp_addr", {12'd0, resp_addr}, 64'd0);
    chk("late_counts", {i_grant_cnt, d_grant_cnt}, 64'd0);
    i_req_valid = 1'b1; i_req_addr = 64'h4444;
    do_walk(1'b1, 64'h4444, 52'h55555, 8'h33, 2);
    chk("post_rst_i_cnt", {32'd0, i_grant_cnt}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tlb_walk_arbiter.md
Name: tlb_walk_arbiter

Overview:
- Shares the single MMU page-walk port between the I-TLB and the D-TLB miss paths.
- Accepts one outstanding translation request at a time, with round-robin fairness between the two requesters.
- Forwards the request to the MMU, then routes the MMU response back to the requester that was granted.
- Sits between the two TLB instances and the MMU. Also provides a stuck-walk watchdog and per-requester grant counters for performance debug.

Parameters:
- VPN_BITS, 64, request address width (matches the TLB/MMU request port).
- EXTENDED_PPN, 52, response physical page number width.
- TIMEOUT_CYCLES, 1024, cycles in WAIT before the watchdog fires; 0 disables the watchdog.
- CNT_W, 32, width of each grant counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req_valid  in  1  I-TLB miss request; held high until its resp pulse
- i_req_addr  in  VPN_BITS  I-TLB request address
- i_resp_valid  out  1  one-cycle response pulse to I-TLB
- d_req_valid  in  1  D-TLB miss request; held high until its resp pulse
- d_req_addr  in  VPN_BITS  D-TLB request address
- d_resp_valid  out  1  one-cycle response pulse to D-TLB
- resp_addr  out  EXTENDED_PPN  registered PPN, broadcast to both TLBs
- resp_perm  out  tlb_perm_bits  registered permission bits, broadcast to both TLBs
- mmu_req_valid  out  1  request to MMU; held until mmu_resp_valid
- mmu_req_addr  out  VPN_BITS  latched address of the granted request
- mmu_resp_valid  in  1  MMU response strobe
- mmu_resp_addr  in  EXTENDED_PPN  MMU PPN
- mmu_resp_perm  in  tlb_perm_bits  MMU permission bits
- timeout_err  out  1  sticky; set when the watchdog fires, cleared only by reset
- i_grant_cnt  out  CNT_W  number of completed I-side walks
- d_grant_cnt  out  CNT_W  number of completed D-side walks

Behaviour:
- Reset values: all outputs 0. State is IDLE. Round-robin pointer last_grant = D, so the I-side wins the first tie.

IDLE:
- No request valid: stay in IDLE.
- Exactly one requester valid: grant it.
- Both valid: grant the requester that is not last_grant.
- On grant, latch its address into mmu_req_addr, register the grant identity, go to WAIT.
- Set mmu_req_valid = 1 on the same edge. The MMU therefore sees the request one cycle after req_valid is first sampled.

WAIT:
- mmu_req_valid and mmu_req_addr are held stable.
- Requester req_valid/req_addr changes are ignored; the latched copy is used.
- The watchdog counter increments each cycle.
- On mmu_resp_valid:
  - Register mmu_resp_addr/perm into resp_addr/resp_perm.
  - Pulse the granted side's resp_valid for exactly one cycle (the cycle after the strobe).
  - Deassert mmu_req_valid.
  - Increment the granted side's counter (wraps modulo 2^CNT_W).
  - Set last_grant = granted side, clear the watchdog, go to GAP.
- On watchdog == TIMEOUT_CYCLES-1 without a response (TIMEOUT_CYCLES != 0):
  - Set timeout_err and stay in WAIT. The request is not dropped.
  - A later response completes normally.

GAP:
- One cycle, during which the serviced TLB drops req_valid (it registers req_valid <= 0 on its resp).
- No arbitration in this cycle; always returns to IDLE.
- Prevents re-granting a stale request.

Other rules:
- resp_addr/resp_perm hold their last value outside pulses.
- i_resp_valid and d_resp_valid are never high together.
- mmu_resp_valid in IDLE or GAP (spurious): ignored, no outputs change.
- Back-to-back: a requester arriving during WAIT is granted in the IDLE cycle following GAP.
- Minimum cadence: 1 cycle grant + MMU latency + 1 GAP cycle.
- Reset mid-WAIT: abandons the walk immediately and clears all outputs. Any later mmu_resp_valid lands in IDLE and is ignored.

Test Plan:
- Single I request, addr 0x1234, MMU responds 3 cycles later with PPN 0xABCDE, perm 0x0F:
  - mmu_req_valid rises 1 cycle after i_req_valid with mmu_req_addr = 0x1234.
  - i_resp_valid pulses 1 cycle with resp_addr = 0xABCDE; d_resp_valid stays 0.
  - i_grant_cnt = 1.
- I and D asserted on the same cycle from reset:
  - I is served first, then D.
  - Next simultaneous pair: I first again (pointer = D after the D service).
  - Grant order I, D, I, D across 4 walks; each counter = 2.
- D request held, I address changes during WAIT:
  - mmu_req_addr stays equal to the latched D address.
  - d_resp_valid pulses; i_resp_valid does not.
- TIMEOUT_CYCLES = 8, MMU silent 20 cycles then responds:
  - timeout_err goes to 1 on WAIT cycle 8 and stays 1.
  - The response at cycle 20 still pulses the correct resp_valid.
- mmu_resp_valid pulsed while IDLE: no resp pulse, counters unchanged.
- reset asserted during WAIT, followed by a late mmu_resp_valid:
  - All outputs 0, state IDLE.
  - The late response is ignored; the next request is granted normally.
